// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C target endpoint.
package i2c_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 4;

  typedef logic [STATE_W-1:0] i2c_slave_state_t;

  localparam i2c_slave_state_t ST_IDLE     = 4'd0;
  localparam i2c_slave_state_t ST_ADDR     = 4'd1;
  localparam i2c_slave_state_t ST_ADDR_ACK = 4'd2;
  localparam i2c_slave_state_t ST_WR_BYTE  = 4'd3;
  localparam i2c_slave_state_t ST_WR_ACK   = 4'd4;
  localparam i2c_slave_state_t ST_RD_BYTE  = 4'd5;
  localparam i2c_slave_state_t ST_RD_ACK   = 4'd6;
  localparam i2c_slave_state_t ST_IGNORE   = 4'd7;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [CNT_W-1:0] BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk and flags edges plus START/STOP conditions.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta_q, scl_sync_q, scl_dly_q;
  logic sda_meta_q, sda_sync_q, sda_dly_q;

  // Two-flop synchronizer plus one delay stage per line; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_dly_q  <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_dly_q  <= scl_sync_q;
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
      sda_dly_q  <= sda_sync_q;
    end
  end

  assign scl_s     = scl_sync_q;
  assign sda_s     = sda_sync_q;
  assign scl_rise  = scl_sync_q & ~scl_dly_q;
  assign scl_fall  = ~scl_sync_q & scl_dly_q;
  // SDA may only move while SCL is low, so an SDA edge with SCL held high is a bus condition.
  assign start_det = scl_sync_q & scl_dly_q & sda_dly_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_dly_q & ~sda_dly_q & sda_sync_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, write-byte receive with ACK, read-byte transmit.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  input  logic [BYTE_W-1:0] tx_data,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_load,
  output logic              busy,
  output logic              rd_nack
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic unused_scl_level;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Synchronized SCL level is only consumed through its edge flags.
  assign unused_scl_level = scl_s;

  i2c_slave_state_t  state_q, state_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              sda_oe_q, sda_oe_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_load_q, tx_load_d;
  logic              rd_nack_q, rd_nack_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      rd_nack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      rd_nack_q  <= rd_nack_d;
    end
  end

  // Next-state logic; bus START/STOP override any in-progress byte.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    rd_nack_d  = 1'b0;

    if (stop_det) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d    = ST_ADDR;
      bitcnt_d   = '0;
      rx_shift_d = '0;
      sda_oe_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise && (bitcnt_q < BITS_PER_BYTE)) begin
            rx_shift_d = {rx_shift_q[BYTE_W-2:0], sda_s};
            bitcnt_d   = bitcnt_q + 4'd1;
          end else if (scl_fall && (bitcnt_q == BITS_PER_BYTE)) begin
            bitcnt_d = '0;
            if (rx_shift_q[BYTE_W-1:1] == SLAVE_ADDR) begin
              state_d  = ST_ADDR_ACK;
              rw_d     = rx_shift_q[0];
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              // Read: first data bit goes out on the same edge that ends the ACK.
              state_d    = ST_RD_BYTE;
              tx_load_d  = 1'b1;
              tx_shift_d = {tx_data[BYTE_W-2:0], 1'b0};
              sda_oe_d   = ~tx_data[BYTE_W-1];
              bitcnt_d   = 4'd1;
            end else begin
              state_d  = ST_WR_BYTE;
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
            end
          end
        end
        ST_WR_BYTE: begin
          if (scl_rise && (bitcnt_q < BITS_PER_BYTE)) begin
            rx_shift_d = {rx_shift_q[BYTE_W-2:0], sda_s};
            bitcnt_d   = bitcnt_q + 4'd1;
          end else if (scl_fall && (bitcnt_q == BITS_PER_BYTE)) begin
            state_d    = ST_WR_ACK;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
            bitcnt_d   = '0;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WR_BYTE;
            sda_oe_d = 1'b0;
          end
        end
        ST_RD_BYTE: begin
          // bitcnt counts bits already presented on the bus.
          if (scl_fall) begin
            if (bitcnt_q == BITS_PER_BYTE) begin
              state_d  = ST_RD_ACK;
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
            end else begin
              sda_oe_d   = ~tx_shift_q[BYTE_W-1];
              tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
              bitcnt_d   = bitcnt_q + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && (sda_s == NACK)) begin
            state_d   = ST_IGNORE;
            rd_nack_d = 1'b1;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
          end else if (scl_fall) begin
            state_d    = ST_RD_BYTE;
            tx_load_d  = 1'b1;
            tx_shift_d = {tx_data[BYTE_W-2:0], 1'b0};
            sda_oe_d   = ~tx_data[BYTE_W-1];
            bitcnt_d   = 4'd1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          bitcnt_d = '0;
        end
      endcase
    end
  end

  // Open-drain: only ever pull low or release.
  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;
  assign rd_nack  = rd_nack_q;

endmodule
